// File: rtl/spi_pkg.sv
// Shared types and widths for the SPI register-access slave.
package spi_pkg;

    localparam int unsigned ADDR_W = 7;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 3;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2
    } spi_state_e;

endpackage

// File: rtl/spi_slave_if.sv
// SPI pins plus the regwrap-side address/data handshake.
interface spi_slave_if;
    import spi_pkg::*;

    logic              sclk;
    logic              cs_n;
    logic              mosi;
    logic              miso;
    logic              miso_oe;
    logic [ADDR_W-1:0] addr;
    logic              addr_dv;
    logic              rw_out;
    logic [DATA_W-1:0] rx_d;
    logic              rxdv;
    logic [DATA_W-1:0] tx_d;

    modport slave (
        input  sclk, cs_n, mosi, tx_d,
        output miso, miso_oe, addr, addr_dv, rw_out, rx_d, rxdv
    );

    modport master (
        output sclk, cs_n, mosi, tx_d,
        input  miso, miso_oe, addr, addr_dv, rw_out, rx_d, rxdv
    );

endinterface

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one asynchronous input with registered edge pulses.
module spi_sync #(
    parameter int unsigned STAGES  = 2,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);
    logic [STAGES-1:0] sync_q;
    logic              prev_q;
    logic              rise_q;
    logic              fall_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
            rise_q <= sync_q[STAGES-1] & ~prev_q;
            fall_q <= ~sync_q[STAGES-1] & prev_q;
        end
    end

    assign level_o = sync_q[STAGES-1];
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 register-access slave: decodes a {rw,addr} command byte, then
// streams write bytes to, or read bytes from, a register wrapper with auto-increment.
module spi_slave
    import spi_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    spi_slave_if.slave bus
);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic [2:0]       ARM_CNT  = 3'(SYNC_STAGES + 1);

    logic sclk_rise, sclk_fall, sclk_lvl_unused;
    logic cs_lvl, cs_rise, cs_fall;
    logic mosi_lvl, mosi_rise_unused, mosi_fall_unused;

    spi_state_e        state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-2:0] shift_q, shift_d;
    logic [DATA_W-2:0] tx_sh_q, tx_sh_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] rxd_q, rxd_d;
    logic              rw_q, rw_d;
    logic              addr_dv_q, addr_dv_d;
    logic              rxdv_q, rxdv_d;
    logic              miso_q, miso_d;
    logic              miso_oe_q, miso_oe_d;
    logic              tx_pend_q, tx_pend_d;
    logic [2:0]        arm_q, arm_d;
    logic [DATA_W-1:0] byte_c;
    logic              armed_c;

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .reset(reset), .d_i(bus.sclk),
        .level_o(sclk_lvl_unused), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk(clk), .reset(reset), .d_i(bus.cs_n),
        .level_o(cs_lvl), .rise_o(cs_rise), .fall_o(cs_fall)
    );

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .reset(reset), .d_i(bus.mosi),
        .level_o(mosi_lvl), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused)
    );

    // A frame may start only after cs_n has really been seen high since reset.
    assign armed_c = (arm_q == ARM_CNT);

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (cs_fall && armed_c) state_d = CMD;
            CMD:     if (sclk_rise && bit_cnt_q == LAST_BIT) state_d = DATA;
            DATA:    state_d = DATA;
            default: state_d = IDLE;
        endcase
        if (cs_rise) state_d = IDLE;
    end

    always_comb begin
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        tx_sh_d   = tx_sh_q;
        addr_d    = addr_q;
        rxd_d     = rxd_q;
        rw_d      = rw_q;
        addr_dv_d = 1'b0;
        rxdv_d    = 1'b0;
        miso_d    = miso_q;
        miso_oe_d = miso_oe_q;
        tx_pend_d = tx_pend_q;
        arm_d     = arm_q;
        byte_c    = {shift_q, mosi_lvl};

        if (!armed_c) arm_d = cs_lvl ? arm_q + 3'd1 : 3'd0;

        // Write address advances only after its strobe has been presented.
        if (rxdv_q) addr_d = addr_q + ADDR_W'(1);

        if (state_q == IDLE) begin
            bit_cnt_d = '0;
        end else if (!cs_rise) begin
            if (sclk_rise) begin
                shift_d   = byte_c[DATA_W-2:0];
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
                if (bit_cnt_q == LAST_BIT) begin
                    if (state_q == CMD) begin
                        addr_d = byte_c[ADDR_W-1:0];
                        rw_d   = byte_c[DATA_W-1];
                        if (byte_c[DATA_W-1] == RW_READ) begin
                            addr_dv_d = 1'b1;
                            tx_pend_d = 1'b1;
                        end
                    end else if (rw_q == RW_READ) begin
                        addr_d    = addr_q + ADDR_W'(1);
                        addr_dv_d = 1'b1;
                        tx_pend_d = 1'b1;
                    end else begin
                        rxd_d     = byte_c;
                        rxdv_d    = 1'b1;
                        addr_dv_d = 1'b1;
                    end
                end
            end
            if (sclk_fall && state_q == DATA && rw_q == RW_READ) begin
                if (tx_pend_q) begin
                    miso_d    = bus.tx_d[DATA_W-1];
                    tx_sh_d   = bus.tx_d[DATA_W-2:0];
                    miso_oe_d = 1'b1;
                    tx_pend_d = 1'b0;
                end else begin
                    {miso_d, tx_sh_d} = {tx_sh_q, 1'b0};
                end
            end
        end

        if (cs_lvl || state_q == IDLE) begin
            miso_d    = 1'b0;
            miso_oe_d = 1'b0;
            tx_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt_q <= '0;
            shift_q   <= '0;
            tx_sh_q   <= '0;
            addr_q    <= '0;
            rxd_q     <= '0;
            rw_q      <= 1'b0;
            addr_dv_q <= 1'b0;
            rxdv_q    <= 1'b0;
            miso_q    <= 1'b0;
            miso_oe_q <= 1'b0;
            tx_pend_q <= 1'b0;
            arm_q     <= '0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            tx_sh_q   <= tx_sh_d;
            addr_q    <= addr_d;
            rxd_q     <= rxd_d;
            rw_q      <= rw_d;
            addr_dv_q <= addr_dv_d;
            rxdv_q    <= rxdv_d;
            miso_q    <= miso_d;
            miso_oe_q <= miso_oe_d;
            tx_pend_q <= tx_pend_d;
            arm_q     <= arm_d;
        end
    end

    assign bus.miso    = miso_q;
    assign bus.miso_oe = miso_oe_q;
    assign bus.addr    = addr_q;
    assign bus.addr_dv = addr_dv_q;
    assign bus.rw_out  = rw_q;
    assign bus.rx_d    = rxd_q;
    assign bus.rxdv    = rxdv_q;

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of flops in each sclk/cs_n/mosi synchronizer (legal 2..3).
REQ-002 clk  input  1  system clock; sclk frequency SHALL be at most clk/8.
REQ-003 reset  input  1  reset, synchronous and active-high.
REQ-004 sclk  input  1  SPI serial clock, mode 0 (CPOL=0, CPHA=0), asynchronous to clk.
REQ-005 cs_n  input  1  SPI chip select, active-low, asynchronous.
REQ-006 mosi  input  1  SPI data in, MSB first.
REQ-007 miso  output  1  SPI data out, MSB first.
REQ-008 miso_oe  output  1  miso output enable; high only while selected in a read data byte.
REQ-009 addr  output  7  register address to regwrap.
REQ-010 addr_dv  output  1  one-cycle strobe: addr and rw_out valid.
REQ-011 rw_out  output  1  1 = read, 0 = write; held stable between addr_dv strobes.
REQ-012 rx_d  output  8  write data to regwrap; held until the next rxdv.
REQ-013 rxdv  output  1  one-cycle strobe: rx_d valid (write only).
REQ-014 tx_d  input  8  read data from regwrap; valid no later than 2 clk after addr_dv with rw_out=1.

Function
REQ-015 Frame = cs_n low; byte 0 = {rw, addr[6:0]}; bytes 1..N = data; cs_n high ends the frame.
REQ-016 mosi is captured on the synchronized sclk rising edge; miso changes on the synchronized sclk falling edge.
REQ-017 FSM states IDLE, CMD, DATA; IDLE->CMD on synchronized cs_n falling edge; CMD->DATA after 8th bit of byte 0; DATA stays until cs_n rises; any state->IDLE on cs_n rising edge.
REQ-018 Bit counter 3 bits, cleared on entering CMD and after every completed byte; wraps 7->0.
REQ-019 Byte 0 complete: addr<=byte0[6:0], rw_out<=byte0[7]; if read, addr_dv pulses exactly one cycle, SYNC_STAGES+2 clk after the sclk rising edge at the pin.
REQ-020 Write data byte complete: rx_d<=byte, addr_dv and rxdv pulse together in the same single cycle with the current addr; same latency as REQ-019.
REQ-021 Read: tx_d loaded into the shift register on the first synchronized sclk falling edge after addr_dv; bit 7 driven on miso in that cycle, miso_oe high.
REQ-022 Burst: after each data byte, addr increments modulo 128 (7'h7F -> 7'h00); for reads, addr_dv pulses with the new addr at the end of each data byte; MOSI ignored during reads.
REQ-023 cs_n rising mid-byte: partial byte discarded, no addr_dv/rxdv, miso_oe low within SYNC_STAGES+1 clk.
REQ-024 cs_n rising in the same cycle as the 8th rising edge: the byte is discarded (cs_n takes priority).
REQ-025 miso = 0 whenever miso_oe is low.

Reset
REQ-026 While reset is high at a clk edge: state=IDLE, addr=0, rw_out=0, rx_d=0, addr_dv=0, rxdv=0, miso=0, miso_oe=0, synchronizers=idle (sclk=0, cs_n=1, mosi=0).
REQ-027 Reset mid-frame aborts the frame; after reset release, the block waits for a fresh cs_n falling edge and does not resume the aborted frame.

Structure
REQ-028 Package spi_pkg holds the state enum (IDLE, CMD, DATA), ADDR_W=7, DATA_W=8 and the read/write bit encoding.
REQ-029 Sub-module spi_sync, instantiated three times, provides the SYNC_STAGES synchronizer plus registered rise/fall pulse outputs.

Verification
REQ-030 Write frame 0x75,0xA5 (sclk=clk/8) -> one cycle with addr_dv=rxdv=1, addr=7'h75, rw_out=0, rx_d=8'hA5.
REQ-031 Read frame 0xA4 then 8 clocks, regwrap model returns 8'h55 -> addr_dv with addr=7'h24, rw_out=1; miso shifts 0,1,0,1,0,1,0,1; rxdv never asserted.
REQ-032 Write burst 0x7F,0x11,0x22 -> strobes at addr 7'h7F (rx_d=8'h11), then 7'h00 (rx_d=8'h22).
REQ-033 cs_n raised after 5 bits of a write data byte -> no rxdv, no addr_dv; next frame 0x01,0x3C -> addr=7'h01, rx_d=8'h3C.
REQ-034 Reset asserted mid read data byte -> all outputs at reset values next cycle, miso_oe=0; the following full frame decodes correctly.
